// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcodes and
// the instruction word field layout.
package proc_sequencer_pkg;

  localparam int INSTR_W = 16;

  // Instruction word layout: [15:14] F, [13:12] Rx, [11:10] Ry, [9:8] reserved, [7:0] imm
  localparam int F_LSB   = 14;
  localparam int RX_LSB  = 12;
  localparam int RY_LSB  = 10;
  localparam int RSV_LSB = 8;
  localparam int IMM_LSB = 0;

  localparam logic [1:0] OP_MVI = 2'b00;
  localparam logic [1:0] OP_MV  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/proc_sequencer_prog_mem.sv
// Program store: DEPTH x 16 register array, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module prog_mem
  import proc_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/proc_sequencer.sv
// Instruction issuer for the 8-bit bus processor: steps through program memory,
// presenting one instruction per w pulse and waiting for Done before the next.
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          LdEn,
  input  logic [AW-1:0] LdAddr,
  input  logic [15:0]   LdData,
  input  logic          Start,
  input  logic [AW:0]   Len,
  input  logic          Done,
  output logic          w,
  output logic [1:0]    F,
  output logic [1:0]    Rx,
  output logic [1:0]    Ry,
  output logic [7:0]    Data,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [AW-1:0] PC,
  output logic [2:0]    dbg_state
);

  // Handshake: w is high for exactly one cycle per instruction; F/Rx/Ry/Data stay
  // stable from that cycle until Done is seen in WAIT. Done outside WAIT is ignored.

  localparam int          CW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          w_q, w_d;
  logic [1:0]    f_q, f_d, rx_q, rx_d, ry_q, ry_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;
  logic          error_q, error_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [AW:0]   len_clamp;
  logic          last_instr;
  logic          unused_rsvd;

  prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (Clock),
    .we    (LdEn && !busy_q),
    .waddr (LdAddr),
    .wdata (LdData),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // The only reads are the first word at Start and the next word on Done.
  assign rd_addr     = (state_q == ST_WAIT) ? pc_q + AW'(1) : '0;
  assign len_clamp   = (Len > DEPTH_L) ? DEPTH_L : Len;
  assign last_instr  = ({1'b0, pc_q} == len_q - (AW+1)'(1));
  assign unused_rsvd = ^rd_data[RSV_LSB +: 2];

  always_comb begin
    state_d  = state_q;
    w_d      = 1'b0;
    f_d      = f_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    data_d   = data_q;
    busy_d   = busy_q;
    halted_d = halted_q;
    error_d  = error_q;
    pc_d     = pc_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: begin
        if (Start) begin
          halted_d = 1'b0;
          error_d  = 1'b0;
          if (Len == '0) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            len_d   = len_clamp;
            pc_d    = '0;
            w_d     = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            f_d     = rd_data[F_LSB +: 2];
            rx_d    = rd_data[RX_LSB +: 2];
            ry_d    = rd_data[RY_LSB +: 2];
            data_d  = rd_data[IMM_LSB +: 8];
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // Done has priority over a timeout landing in the same cycle.
        if (Done) begin
          if (last_instr) begin
            state_d  = ST_HALT;
            busy_d   = 1'b0;
            halted_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            pc_d    = pc_q + AW'(1);
            w_d     = 1'b1;
            cnt_d   = '0;
            f_d     = rd_data[F_LSB +: 2];
            rx_d    = rd_data[RX_LSB +: 2];
            ry_d    = rd_data[RY_LSB +: 2];
            data_d  = rd_data[IMM_LSB +: 8];
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= ST_IDLE;
      w_q      <= 1'b0;
      f_q      <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      f_q      <= f_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  assign w         = w_q;
  assign F         = f_q;
  assign Rx        = rx_q;
  assign Ry        = ry_q;
  assign Data      = data_q;
  assign Busy      = busy_q;
  assign Halted    = halted_q;
  assign Error     = error_q;
  assign PC        = pc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: a small processor model answers w with Done after the
// opcode latency; runs are compared against timing/register expectations.
module tb_proc_sequencer;
  import proc_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        LdEn = 1'b0;
  logic [3:0]  LdAddr = '0;
  logic [15:0] LdData = '0;
  logic        Start = 1'b0;
  logic [4:0]  Len = '0;
  logic        Done;
  logic        w;
  logic [1:0]  F, Rx, Ry;
  logic [7:0]  Data;
  logic        Busy, Halted, Error;
  logic [3:0]  PC;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  proc_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData),
    .Start(Start), .Len(Len), .Done(Done), .w(w), .F(F), .Rx(Rx), .Ry(Ry),
    .Data(Data), .Busy(Busy), .Halted(Halted), .Error(Error), .PC(PC),
    .dbg_state(dbg_state)
  );

  // ---------------- processor model ----------------
  logic        p_busy;
  int          p_cnt;
  logic [13:0] p_fld;   // {F, Rx, Ry, Data} captured while w is high
  logic [7:0]  p_reg [4];
  logic        p_mute = 1'b0;

  assign Done = p_busy && !p_mute && (p_cnt == (p_fld[13] ? 3 : 1));

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      p_busy <= 1'b0;
      p_cnt  <= 0;
      p_fld  <= '0;
      for (int i = 0; i < 4; i++) p_reg[i] <= '0;
    end else begin
      if (p_busy && Done) begin
        p_busy <= 1'b0;
        case (p_fld[13:12])
          OP_MVI:  p_reg[p_fld[11:10]] <= p_fld[7:0];
          OP_MV:   p_reg[p_fld[11:10]] <= p_reg[p_fld[9:8]];
          OP_ADD:  p_reg[p_fld[11:10]] <= p_reg[p_fld[11:10]] + p_reg[p_fld[9:8]];
          default: p_reg[p_fld[11:10]] <= p_reg[p_fld[11:10]] - p_reg[p_fld[9:8]];
        endcase
      end else if (p_busy) begin
        p_cnt <= p_cnt + 1;
      end
      if (w) begin
        p_busy <= 1'b1;
        p_cnt  <= 1;
        p_fld  <= {F, Rx, Ry, Data};
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] mem_model [16];
  logic [7:0]  exp_reg [4];
  logic [31:0] obs_q [$];   // {PC, F, Rx, Ry, Data, cycle[13:0]} per w pulse
  logic [31:0] exp_q [$];
  int          end_cyc;
  logic        end_err;

  typedef struct {
    logic [15:0] word;
    logic [1:0]  f, rx, ry;
    logic [7:0]  data;
    int          halt_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_word(input int addr, input logic [15:0] word);
    @(negedge Clock);
    LdEn = 1'b1; LdAddr = 4'(addr); LdData = word;
    @(negedge Clock);
    LdEn = 1'b0;
    mem_model[addr] = word;
  endtask

  task automatic clear_exp_regs();
    for (int i = 0; i < 4; i++) exp_reg[i] = '0;
  endtask

  // Start a run and observe it cycle by cycle (cycle 0 = first cycle after Start).
  // inj_cyc: cycle at which a write to mem[1] and a Start are attempted.
  // rst_cyc: cycle at which Resetn is pulled low (run abandoned there).
  task automatic run(input int len_in, input int inj_cyc, input int rst_cyc);
    logic [13:0] cur;
    logic        have;
    have = 1'b0;
    cur = '0;
    obs_q.delete();
    end_cyc = -1;
    end_err = 1'b0;
    @(negedge Clock);
    Len = 5'(len_in);
    Start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clock);
      Start = 1'b0;
      LdEn = 1'b0;
      if (w) begin
        cur = {F, Rx, Ry, Data};
        have = 1'b1;
        obs_q.push_back({PC, F, Rx, Ry, Data, 14'(k)});
      end else if (Busy && have) begin
        chk("hold_fields", 32'({F, Rx, Ry, Data}), 32'(cur));
      end
      if (!Busy && (Halted || Error)) begin
        end_cyc = k;
        end_err = Error;
        break;
      end
      if (k == rst_cyc) begin
        Resetn = 1'b0;
        #1;
        chk("async_reset_outs", 32'({w, F, Rx, Ry, Data, Busy, Halted, Error, PC}), 32'h0);
        end_cyc = k;
        break;
      end
      if (k == inj_cyc) begin
        LdEn = 1'b1; LdAddr = 4'd1; LdData = 16'h0099;
        Start = 1'b1; Len = 5'd1;
      end
    end
    if (end_cyc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL run_bound: run did not end within 200 cycles");
    end
  endtask

  // Reference: each instruction occupies ISSUE + latency WAIT cycles
  // (1 for mvi/mv, 3 for add/sub); registers follow the opcode arithmetic.
  task automatic check_run(input string tag, input int len_in);
    int          eff;
    int          t;
    logic [15:0] wd;
    logic [1:0]  rx, ry;
    eff = (len_in > 16) ? 16 : len_in;
    t = 0;
    exp_q.delete();
    for (int i = 0; i < eff; i++) begin
      wd = mem_model[i];
      rx = wd[13:12];
      ry = wd[11:10];
      exp_q.push_back({4'(i), wd[15:10], wd[7:0], 14'(t)});
      t += (wd[15:14] == OP_ADD || wd[15:14] == OP_SUB) ? 4 : 2;
      case (wd[15:14])
        OP_MVI:  exp_reg[rx] = wd[7:0];
        OP_MV:   exp_reg[rx] = exp_reg[ry];
        OP_ADD:  exp_reg[rx] = exp_reg[rx] + exp_reg[ry];
        default: exp_reg[rx] = exp_reg[rx] - exp_reg[ry];
      endcase
    end
    chk({tag, " pulses"}, 32'(obs_q.size()), 32'(eff));
    for (int i = 0; i < eff && i < obs_q.size(); i++)
      chk({tag, " issue"}, obs_q[i], exp_q[i]);
    chk({tag, " end_cycle"}, 32'(end_cyc), 32'(t));
    chk({tag, " error"}, 32'(end_err), 32'h0);
    if (eff > 0) chk({tag, " last_pc"}, 32'(PC), 32'(eff - 1));
    chk({tag, " regs"}, {p_reg[3], p_reg[2], p_reg[1], p_reg[0]},
        {exp_reg[3], exp_reg[2], exp_reg[1], exp_reg[0]});
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs [5];
    int   len_r;

    vecs[0] = '{16'h0055, 2'b00, 2'd0, 2'd0, 8'h55, 2};   // mvi R0,0x55
    vecs[1] = '{16'h4A00, 2'b01, 2'd0, 2'd2, 8'h00, 2};   // mv R0,R2
    vecs[2] = '{16'h9733, 2'b10, 2'd1, 2'd1, 8'h33, 4};   // add with reserved bits set
    vecs[3] = '{16'hFFFF, 2'b11, 2'd3, 2'd3, 8'hFF, 4};   // sub, all ones
    vecs[4] = '{16'h2CA5, 2'b00, 2'd2, 2'd3, 8'hA5, 2};   // mvi R2,0xA5

    clear_exp_regs();
    repeat (3) @(negedge Clock);
    chk("rst_w", 32'(w), 32'h0);
    chk("rst_fields", 32'({F, Rx, Ry, Data}), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_halted", 32'(Halted), 32'h0);
    chk("rst_error", 32'(Error), 32'h0);
    chk("rst_pc", 32'(PC), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    Resetn = 1'b1;

    // Single-instruction table
    for (int i = 0; i < 5; i++) begin
      load_word(0, vecs[i].word);
      run(1, -1, -1);
      if (obs_q.size() > 0)
        chk("tbl_fields", 32'(obs_q[0][27:14]),
            32'({vecs[i].f, vecs[i].rx, vecs[i].ry, vecs[i].data}));
      chk("tbl_halt_cycle", 32'(end_cyc), 32'(vecs[i].halt_cyc));
      check_run("tbl", 1);
    end

    // mvi R0,5; mvi R1,3; add R0,R1; sub R0,R1
    load_word(0, 16'h0005);
    load_word(1, 16'h1003);
    load_word(2, 16'h8400);
    load_word(3, 16'hC400);
    run(4, -1, -1);
    if (obs_q.size() == 4) begin
      chk("prog4_w1", 32'(obs_q[1][13:0]), 32'd2);
      chk("prog4_w2", 32'(obs_q[2][13:0]), 32'd4);
      chk("prog4_w3", 32'(obs_q[3][13:0]), 32'd8);
    end
    chk("prog4_halt", 32'(end_cyc), 32'd12);
    chk("prog4_r0", 32'(p_reg[0]), 32'd5);
    check_run("prog4", 4);

    // Done never arrives
    p_mute = 1'b1;
    load_word(0, 16'h8400);
    run(1, -1, -1);
    chk("to_error", 32'(end_err), 32'h1);
    chk("to_cycle", 32'(end_cyc), 32'd16);
    chk("to_w", 32'(w), 32'h0);
    chk("to_busy", 32'(Busy), 32'h0);
    p_mute = 1'b0;

    // Len=0 straight after an error: halts, clears Error, no w pulse
    run(0, -1, -1);
    chk("len0_halted", 32'(Halted), 32'h1);
    check_run("len0", 0);

    load_word(0, 16'h0005);
    run(1, -1, -1);
    check_run("after_err", 1);

    // Write and Start attempted while busy must be ignored
    load_word(0, 16'h0011);
    load_word(1, 16'h1022);
    run(2, 0, -1);
    if (obs_q.size() == 2) chk("busy_ld_data", 32'(obs_q[1][21:14]), 32'h22);
    check_run("busy_ld", 2);

    // Reset in the WAIT of the third instruction, then rerun
    load_word(0, 16'h0005);
    load_word(1, 16'h1003);
    load_word(2, 16'h8400);
    load_word(3, 16'hC400);
    run(4, -1, 5);
    @(negedge Clock);
    Resetn = 1'b1;
    clear_exp_regs();
    chk("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    run(4, -1, -1);
    check_run("rerun", 4);

    // Random programs, including lengths beyond DEPTH
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 16; a++) load_word(a, 16'($urandom_range(0, 65535)));
      len_r = int'($urandom_range(1, 20));
      run(len_r, -1, -1);
      check_run("rand", len_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
